// File: rtl/fp_add_arbiter.sv
// Two-requester round-robin front end that time-shares one combinational fp_add.
// Accepted operands run IDLE -> EXEC -> RESP and return tagged with the requester ID.

module fp_add #(
  parameter int i1 = 2,
  parameter int f1 = 14,
  parameter int i2 = 2,
  parameter int f2 = 14,
  parameter int i3 = 2,
  parameter int f3 = 8
) (
  input  logic [i1+f1-1:0] a,
  input  logic             s1,
  input  logic [i2+f2-1:0] b,
  input  logic             s2,
  output logic [i3+f3-1:0] c,
  output logic             sign,
  output logic             overflow,
  output logic             underflow
);
  localparam int N1 = i1 + f1;
  localparam int N2 = i2 + f2;
  localparam int N3 = i3 + f3;
  localparam int FM = (f1 > f2) ? f1 : f2;
  localparam int IM = (i1 > i2) ? i1 : i2;
  localparam int SL = (f3 > FM) ? f3 - FM : 0;
  localparam int SR = (FM > f3) ? FM - f3 : 0;
  localparam int WA = IM + FM + SL + 3;
  localparam int W  = (WA > N3 + 2) ? WA : N3 + 2;

  localparam logic signed [W-1:0] SMAX = W'((64'sd1 <<< (N3 - 1)) - 64'sd1);
  localparam logic signed [W-1:0] SMIN = -SMAX - W'(1);
  localparam logic signed [W-1:0] UMAX = W'((64'sd1 <<< N3) - 64'sd1);

  logic signed [W-1:0] ax, bx, sum, q;
  logic                rs;

  // Result is signed whenever either operand is; quantization truncates toward -inf.
  always_comb begin
    if (s1) ax = {{(W-N1){a[N1-1]}}, a};
    else    ax = {{(W-N1){1'b0}}, a};
    if (s2) bx = {{(W-N2){b[N2-1]}}, b};
    else    bx = {{(W-N2){1'b0}}, b};
    ax  = ax <<< (FM - f1 + SL);
    bx  = bx <<< (FM - f2 + SL);
    sum = ax + bx;
    q   = sum >>> SR;
    rs  = s1 | s2;

    c        = q[N3-1:0];
    overflow = 1'b0;
    if (rs) begin
      if (q > SMAX) begin
        overflow = 1'b1;
        c        = SMAX[N3-1:0];
      end else if (q < SMIN) begin
        overflow = 1'b1;
        c        = SMIN[N3-1:0];
      end
    end else if (q > UMAX) begin
      overflow = 1'b1;
      c        = UMAX[N3-1:0];
    end
    sign      = rs && (sum < 0);
    underflow = (sum != '0) && (q == '0);
  end
endmodule

module fp_add_arbiter #(
  parameter int i1    = 2,
  parameter int f1    = 14,
  parameter int i2    = 2,
  parameter int f2    = 14,
  parameter int i3    = 2,
  parameter int f3    = 8,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [i1+f1-1:0]   req0_a,
  input  logic               req0_s1,
  input  logic [i2+f2-1:0]   req0_b,
  input  logic               req0_s2,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [i1+f1-1:0]   req1_a,
  input  logic               req1_s1,
  input  logic [i2+f2-1:0]   req1_b,
  input  logic               req1_s2,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [i3+f3-1:0]   rsp_c,
  output logic               rsp_sign,
  output logic               rsp_overflow,
  output logic               rsp_underflow,
  output logic [CNT_W-1:0]   err_count,
  output logic               busy
);
  localparam int NA = i1 + f1;
  localparam int NB = i2 + f2;
  localparam int NC = i3 + f3;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state_q, state_d;
  logic              ptr_q, ptr_d;
  logic              id_q, id_d;
  logic [NA-1:0]     a_q, a_d;
  logic [NB-1:0]     b_q, b_d;
  logic              s1_q, s1_d, s2_q, s2_d;
  logic              rsp_id_q, rsp_id_d;
  logic [NC-1:0]     rsp_c_q, rsp_c_d;
  logic              rsp_sign_q, rsp_sign_d;
  logic              rsp_ovf_q, rsp_ovf_d;
  logic              rsp_udf_q, rsp_udf_d;
  logic [CNT_W-1:0]  err_q, err_d;

  logic [1:0]           req_valid, req_ready;
  logic [1:0][NA-1:0]   req_a;
  logic [1:0][NB-1:0]   req_b;
  logic [1:0]           req_s1, req_s2;
  logic                 grant;

  logic [NC-1:0] fa_c;
  logic          fa_sign, fa_ovf, fa_udf;

  assign req_valid = {req1_valid, req0_valid};
  assign req_a     = {req1_a, req0_a};
  assign req_b     = {req1_b, req0_b};
  assign req_s1    = {req1_s1, req0_s1};
  assign req_s2    = {req1_s2, req0_s2};

  fp_add #(.i1(i1), .f1(f1), .i2(i2), .f2(f2), .i3(i3), .f3(f3)) u_fp_add (
    .a(a_q), .s1(s1_q), .b(b_q), .s2(s2_q),
    .c(fa_c), .sign(fa_sign), .overflow(fa_ovf), .underflow(fa_udf)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    id_d       = id_q;
    a_d        = a_q;
    b_d        = b_q;
    s1_d       = s1_q;
    s2_d       = s2_q;
    rsp_id_d   = rsp_id_q;
    rsp_c_d    = rsp_c_q;
    rsp_sign_d = rsp_sign_q;
    rsp_ovf_d  = rsp_ovf_q;
    rsp_udf_d  = rsp_udf_q;
    err_d      = err_q;
    req_ready  = '0;

    // Pointer only matters on contention; a lone requester always wins.
    grant = ptr_q;
    if (req_valid == 2'b01)      grant = 1'b0;
    else if (req_valid == 2'b10) grant = 1'b1;

    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          req_ready[grant] = 1'b1;
          a_d     = req_a[grant];
          b_d     = req_b[grant];
          s1_d    = req_s1[grant];
          s2_d    = req_s2[grant];
          id_d    = grant;
          ptr_d   = ~grant;
          state_d = EXEC;
        end
      end
      EXEC: begin
        rsp_c_d    = fa_c;
        rsp_sign_d = fa_sign;
        rsp_ovf_d  = fa_ovf;
        rsp_udf_d  = fa_udf;
        rsp_id_d   = id_q;
        if ((fa_ovf | fa_udf) && (err_q != {CNT_W{1'b1}})) err_d = err_q + 1'b1;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (rst) req_ready = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= 1'b0;
      id_q       <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      rsp_id_q   <= 1'b0;
      rsp_c_q    <= '0;
      rsp_sign_q <= 1'b0;
      rsp_ovf_q  <= 1'b0;
      rsp_udf_q  <= 1'b0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      id_q       <= id_d;
      a_q        <= a_d;
      b_q        <= b_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      rsp_id_q   <= rsp_id_d;
      rsp_c_q    <= rsp_c_d;
      rsp_sign_q <= rsp_sign_d;
      rsp_ovf_q  <= rsp_ovf_d;
      rsp_udf_q  <= rsp_udf_d;
      err_q      <= err_d;
    end
  end

  assign req0_ready    = req_ready[0];
  assign req1_ready    = req_ready[1];
  assign rsp_valid     = (state_q == RESP);
  assign busy          = (state_q != IDLE);
  assign rsp_id        = rsp_id_q;
  assign rsp_c         = rsp_c_q;
  assign rsp_sign      = rsp_sign_q;
  assign rsp_overflow  = rsp_ovf_q;
  assign rsp_underflow = rsp_udf_q;
  assign err_count     = err_q;
endmodule

// File: tb/tb_fp_add_arbiter.sv
// Directed bench for fp_add_arbiter: vector table on requester 0 plus
// hand-written sequences for arbitration, backpressure, saturation and reset.
module tb_fp_add_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_s1, req0_s2;
  logic [15:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_s1, req1_s2;
  logic [15:0] req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_sign, rsp_overflow, rsp_underflow;
  logic [9:0]  rsp_c;
  logic [7:0]  err_count;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_add_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
    .req0_s1(req0_s1), .req0_b(req0_b), .req0_s2(req0_s2),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
    .req1_s1(req1_s1), .req1_b(req1_b), .req1_s2(req1_s2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_c(rsp_c), .rsp_sign(rsp_sign), .rsp_overflow(rsp_overflow),
    .rsp_underflow(rsp_underflow), .err_count(err_count), .busy(busy)
  );

  typedef struct {
    logic [15:0] a;
    logic        s1;
    logic [15:0] b;
    logic        s2;
    logic [9:0]  c;
    logic        sign;
    logic        ovf;
    logic        udf;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Issue on one requester, wait for its accept, then count negedges until rsp_valid.
  task automatic run_op(input bit id, input logic [15:0] a, input logic s1,
                        input logic [15:0] b, input logic s2, output int lat);
    int n;
    if (id == 1'b0) begin
      req0_a = a; req0_s1 = s1; req0_b = b; req0_s2 = s2; req0_valid = 1'b1;
    end else begin
      req1_a = a; req1_s1 = s1; req1_b = b; req1_s2 = s2; req1_valid = 1'b1;
    end
    n = 0;
    @(negedge clk);
    while (!(id ? req1_ready : req0_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("accept_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1;
    if (id == 1'b0) req0_valid = 1'b0;
    else            req1_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 20);
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  initial begin
    int lat, exp_err;
    int g[$], gc[$], r[$];
    logic [9:0] hold_c;
    logic hold_id, hold_ovf, hold_udf, hold_sign;

    //            a        s1    b        s2    c       sign  ovf   udf
    vecs[0] = '{16'h2000, 1'b0, 16'h1000, 1'b0, 10'h0C0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'hC000, 1'b0, 16'hC000, 1'b0, 10'h3FF, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{16'hE000, 1'b1, 16'h1000, 1'b1, 10'h3C0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{16'h0001, 1'b0, 16'h0001, 1'b0, 10'h000, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{16'h4000, 1'b1, 16'h4000, 1'b1, 10'h1FF, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{16'h8000, 1'b1, 16'hC000, 1'b1, 10'h200, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{16'h8000, 1'b0, 16'hF000, 1'b1, 10'h1C0, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = '0; req0_b = '0; req0_s1 = 1'b0; req0_s2 = 1'b0;
    req1_valid = 1'b1; req1_a = '0; req1_b = '0; req1_s1 = 1'b0; req1_s2 = 1'b0;

    // Reset state, readys forced low while rst is high.
    repeat (2) @(negedge clk);
    chk("rst_ready0", 32'(req0_ready), 32'd0);
    chk("rst_ready1", 32'(req1_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err_count), 32'd0);
    chk("rst_rsp_c", 32'(rsp_c), 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;

    // Vector table on requester 0.
    exp_err = 0;
    for (int i = 0; i < 7; i++) begin
      run_op(1'b0, vecs[i].a, vecs[i].s1, vecs[i].b, vecs[i].s2, lat);
      exp_err += (vecs[i].ovf | vecs[i].udf) ? 1 : 0;
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'd2);
      chk($sformatf("v%0d_id", i), 32'(rsp_id), 32'd0);
      chk($sformatf("v%0d_c", i), 32'(rsp_c), 32'(vecs[i].c));
      chk($sformatf("v%0d_sign", i), 32'(rsp_sign), 32'(vecs[i].sign));
      chk($sformatf("v%0d_ovf", i), 32'(rsp_overflow), 32'(vecs[i].ovf));
      chk($sformatf("v%0d_udf", i), 32'(rsp_underflow), 32'(vecs[i].udf));
      chk($sformatf("v%0d_err", i), 32'(err_count), 32'(exp_err));
      consume();
    end

    // Both requesters held valid: grants 0,1,0,1 spaced 3 cycles.
    do_reset();
    req0_a = 16'h2000; req0_b = 16'h1000; req1_a = 16'h1000; req1_b = 16'h1000;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      if (req0_ready && req1_ready) chk("double_grant", 32'd1, 32'd0);
      if (req0_ready) begin g.push_back(0); gc.push_back(k); end
      if (req1_ready) begin g.push_back(1); gc.push_back(k); end
      if (rsp_valid) r.push_back(int'(rsp_id));
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    chk("rr_grant_cnt", 32'(g.size() >= 4), 32'd1);
    chk("rr_rsp_cnt", 32'(r.size() >= 4), 32'd1);
    for (int i = 0; i < 4 && i < g.size(); i++)
      chk($sformatf("rr_grant%0d", i), 32'(g[i]), 32'(i % 2));
    for (int i = 0; i < 3 && i + 1 < gc.size(); i++)
      chk($sformatf("rr_spacing%0d", i), 32'(gc[i+1] - gc[i]), 32'd3);
    for (int i = 0; i < 4 && i < r.size(); i++)
      chk($sformatf("rr_rsp_id%0d", i), 32'(r[i]), 32'(i % 2));

    // Backpressure with requester 1 waiting.
    do_reset();
    run_op(1'b0, 16'h2000, 1'b0, 16'h1000, 1'b0, lat);
    req1_a = 16'hE000; req1_s1 = 1'b1; req1_b = 16'h1000; req1_s2 = 1'b1;
    req1_valid = 1'b1;
    chk("bp_latency", 32'(lat), 32'd2);
    hold_c = rsp_c; hold_id = rsp_id; hold_ovf = rsp_overflow;
    hold_udf = rsp_underflow; hold_sign = rsp_sign;
    chk("bp_c_first", 32'(hold_c), 32'h0C0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp_valid%0d", k), 32'(rsp_valid), 32'd1);
      chk($sformatf("bp_c%0d", k), 32'(rsp_c), 32'(hold_c));
      chk($sformatf("bp_id%0d", k), 32'(rsp_id), 32'(hold_id));
      chk($sformatf("bp_flags%0d", k), 32'({rsp_sign, rsp_overflow, rsp_underflow}),
          32'({hold_sign, hold_ovf, hold_udf}));
      chk($sformatf("bp_ready%0d", k), 32'({req1_ready, req0_ready}), 32'd0);
      chk($sformatf("bp_busy%0d", k), 32'(busy), 32'd1);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", 32'(rsp_valid), 32'd0);
    chk("bp_release_busy", 32'(busy), 32'd0);
    chk("bp_next_grant", 32'(req1_ready), 32'd1);
    @(posedge clk);
    #1 req1_valid = 1'b0;
    rsp_ready = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 20);
    chk("bp_req1_latency", 32'(lat), 32'd2);
    chk("bp_req1_id", 32'(rsp_id), 32'd1);
    chk("bp_req1_c", 32'(rsp_c), 32'h3C0);
    consume();

    // Overflow counting and saturation.
    do_reset();
    run_op(1'b0, 16'hC000, 1'b0, 16'hC000, 1'b0, lat);
    chk("sat_first_ovf", 32'(rsp_overflow), 32'd1);
    chk("sat_first_err", 32'(err_count), 32'd1);
    consume();
    for (int k = 0; k < 299; k++) begin
      run_op(k[0], 16'hC000, 1'b0, 16'hC000, 1'b0, lat);
      consume();
    end
    chk("sat_err_255", 32'(err_count), 32'd255);

    // Reset while the transaction is in EXEC.
    do_reset();
    req0_a = 16'hC000; req0_b = 16'hC000; req0_s1 = 1'b0; req0_s2 = 1'b0;
    req0_valid = 1'b1;
    @(negedge clk);
    chk("mid_accept", 32'(req0_ready), 32'd1);
    @(posedge clk);
    #1;
    req1_valid = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", 32'({req1_ready, req0_ready}), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_no_rsp", 32'(rsp_valid), 32'd0);
    chk("mid_idle", 32'(busy), 32'd0);
    chk("mid_err", 32'(err_count), 32'd0);
    chk("mid_grant0", 32'({req1_ready, req0_ready}), 32'd1);
    @(posedge clk);
    #1 req0_valid = 1'b0; req1_valid = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 20);
    chk("mid_new_latency", 32'(lat), 32'd2);
    chk("mid_new_id", 32'(rsp_id), 32'd0);
    chk("mid_new_err", 32'(err_count), 32'd1);
    consume();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
